// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: types shared by the memory arbiter and its bus interface.
//   word_t      - 32-bit bus word (addresses and data)
//   ramstate_t  - RAM status reported back to the arbiter
//   arb_state_t - grant FSM states
package mem_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side and RAM-side signals of the memory arbiter.
//   slave  - arbiter view: takes cache requests and RAM status, drives
//            waits, load data, RAM strobes/address/store, coherence outputs
//   master - environment view (caches + RAM), the mirror image
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  // cache side
  logic      iREN;
  word_t     iaddr;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      iwait;
  logic      dwait;
  word_t     iload;
  word_t     dload;
  // RAM side
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  // coherence
  logic      ccwait;
  logic      ccinv;
  word_t     ccsnoopaddr;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore,
           ccwait, ccinv, ccsnoopaddr
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore,
           ccwait, ccinv, ccsnoopaddr
  );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the shared RAM to either the icache (read-only) or the
// dcache (read/write-back), one word at a time.
//   CLK, nRST - clock (rising edge), asynchronous active-low reset
//   bus       - mem_arbiter_if.slave: cache requests/waits/loads and RAM
//               strobes/address/store/load/status
//
// state  | meaning
// IDLE   | no grant; arbitrate pending requests for next cycle
// DGRANT | dcache owns the RAM until ACCESS, ERROR or withdrawal
// IGRANT | icache owns the RAM until ACCESS, ERROR or withdrawal
//
// ifair_q remembers that a data transfer just finished while an instruction
// fetch was waiting, so the next IDLE decision must favour the icache.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus
);

  arb_state_t state_q, state_d;
  logic       ifair_q, ifair_d;

  logic       d_req;
  logic       iwait_c, dwait_c;
  logic       ramren_c, ramwen_c;
  word_t      ramaddr_c, ramstore_c;

  assign d_req = bus.dREN | bus.dWEN;

  always_comb begin
    state_d    = state_q;
    ifair_d    = ifair_q;
    iwait_c    = 1'b1;
    dwait_c    = 1'b1;
    ramren_c   = 1'b0;
    ramwen_c   = 1'b0;
    ramaddr_c  = '0;
    ramstore_c = '0;

    case (state_q)
      IDLE: begin
        if (d_req && !ifair_q) begin
          state_d = DGRANT;
        end else if (bus.iREN) begin
          state_d = IGRANT;
        end
      end

      DGRANT: begin
        ramaddr_c  = bus.daddr;
        ramstore_c = bus.dstore;
        // write wins when both strobes are up; nothing is strobed once the
        // dcache has withdrawn
        ramwen_c   = bus.dWEN;
        ramren_c   = bus.dREN & ~bus.dWEN;
        if (!d_req) begin
          state_d = IDLE;
        end else if (bus.ramstate == ACCESS) begin
          dwait_c = 1'b0;
          state_d = IDLE;
          if (bus.iREN) ifair_d = 1'b1;
        end else if (bus.ramstate == ERROR) begin
          state_d = IDLE;
        end
      end

      IGRANT: begin
        ramaddr_c = bus.iaddr;
        ramren_c  = bus.iREN;
        if (!bus.iREN) begin
          state_d = IDLE;
        end else if (bus.ramstate == ACCESS) begin
          iwait_c = 1'b0;
          ifair_d = 1'b0;
          state_d = IDLE;
        end else if (bus.ramstate == ERROR) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      ifair_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ifair_q <= ifair_d;
    end
  end

  assign bus.iwait       = iwait_c;
  assign bus.dwait       = dwait_c;
  assign bus.iload       = bus.ramload;
  assign bus.dload       = bus.ramload;
  assign bus.ramREN      = ramren_c;
  assign bus.ramWEN      = ramwen_c;
  assign bus.ramaddr     = ramaddr_c;
  assign bus.ramstore    = ramstore_c;
  assign bus.ccwait      = 1'b0;
  assign bus.ccinv       = 1'b0;
  assign bus.ccsnoopaddr = '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic CLK = 1'b0;
  logic nRST;

  mem_arbiter_if bus();

  mem_arbiter dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who currently owns the RAM (0 none, 1 dcache, 2 icache)
  // and whether the icache is owed the next grant.
  int   owner;
  bit   owed_i;
  bit   last_d_done, last_i_done;

  task automatic model_reset();
    owner       = 0;
    owed_i      = 0;
    last_d_done = 0;
    last_i_done = 0;
  endtask

  // Called just after a negedge with inputs already driven: checks this
  // cycle's outputs, then advances the model across the next rising edge.
  task automatic step();
    bit        dreq, d_done, i_done, withdrawn;
    logic      e_ren, e_wen;
    word_t     e_addr, e_store;
    int        nxt;
    bit        nxt_owed;
    #1;
    dreq      = bus.dREN | bus.dWEN;
    withdrawn = (owner == 1 && !dreq) || (owner == 2 && !bus.iREN);
    d_done    = owner == 1 && dreq && bus.ramstate == ACCESS;
    i_done    = owner == 2 && bus.iREN && bus.ramstate == ACCESS;
    e_wen     = owner == 1 && bus.dWEN;
    e_ren     = (owner == 1 && bus.dREN && !bus.dWEN) || (owner == 2 && bus.iREN);
    e_addr    = owner == 1 ? bus.daddr : (owner == 2 ? bus.iaddr : 32'h0);
    e_store   = owner == 1 ? bus.dstore : 32'h0;

    chk("dwait",    bus.dwait,    !d_done);
    chk("iwait",    bus.iwait,    !i_done);
    chk("ramREN",   bus.ramREN,   e_ren);
    chk("ramWEN",   bus.ramWEN,   e_wen);
    chk("ramaddr",  bus.ramaddr,  e_addr);
    chk("ramstore", bus.ramstore, e_store);
    chk("iload",    bus.iload,    bus.ramload);
    chk("dload",    bus.dload,    bus.ramload);
    chk("cc",       {bus.ccwait, bus.ccinv, |bus.ccsnoopaddr}, 3'b000);

    nxt_owed = owed_i;
    if (d_done && bus.iREN) nxt_owed = 1;
    if (i_done)             nxt_owed = 0;
    if (owner == 0) begin
      if (dreq && !owed_i)  nxt = 1;
      else if (bus.iREN)    nxt = 2;
      else                  nxt = 0;
    end else if (withdrawn || bus.ramstate == ACCESS || bus.ramstate == ERROR) begin
      nxt = 0;
    end else begin
      nxt = owner;
    end

    last_d_done = d_done;
    last_i_done = i_done;
    @(posedge CLK);
    owner  = nxt;
    owed_i = nxt_owed;
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.iaddr = 0; bus.daddr = 0; bus.dstore = 0;
    bus.ramload = 0; bus.ramstate = FREE;
  endtask

  int   seen_i, seen_d;
  bit   prev_was_d;
  int   dd_count;
  int   r;

  initial begin
    idle_inputs();
    nRST = 0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_iwait",   bus.iwait,   1'b1);
    chk("rst_dwait",   bus.dwait,   1'b1);
    chk("rst_ramREN",  bus.ramREN,  1'b0);
    chk("rst_ramWEN",  bus.ramWEN,  1'b0);
    chk("rst_ramaddr", bus.ramaddr, 32'h0);
    nRST = 1;

    // lone icache read, L=2
    bus.iREN = 1; bus.iaddr = 32'h40; bus.ramload = 32'hDEADBEEF;
    step();                                  // cycle 0, idle
    bus.ramstate = BUSY;
    step();                                  // cycle 1
    step();                                  // cycle 2
    bus.ramstate = ACCESS;
    #1;
    chk("lone_iwait_c3", bus.iwait, 1'b0);
    chk("lone_iload_c3", bus.iload, 32'hDEADBEEF);
    chk("lone_ramREN_c3", bus.ramREN, 1'b1);
    step();
    bus.iREN = 0; bus.ramstate = FREE;
    step();

    // simultaneous i and d, L=0: data first, instruction after turnaround
    bus.iREN = 1; bus.iaddr = 32'h80; bus.dREN = 1; bus.daddr = 32'h200;
    bus.ramstate = ACCESS;
    step();                                  // cycle 0
    #1 chk("sim_dwait_c1", bus.dwait, 1'b0);
    step();                                  // cycle 1: D completes
    bus.dREN = 0;
    step();                                  // cycle 2: idle
    #1 chk("sim_iwait_c3", bus.iwait, 1'b0);
    step();                                  // cycle 3: I completes
    bus.iREN = 0; bus.ramstate = FREE;
    step();

    // write-back with dREN and dWEN both high
    bus.dREN = 1; bus.dWEN = 1; bus.daddr = 32'h3100; bus.dstore = 32'h12345678;
    step();
    #1;
    chk("wb_ramWEN", bus.ramWEN, 1'b1);
    chk("wb_ramREN", bus.ramREN, 1'b0);
    chk("wb_addr",   bus.ramaddr, 32'h3100);
    chk("wb_store",  bus.ramstore, 32'h12345678);
    bus.ramstate = ERROR;                    // error: no pulse, retry
    step();
    bus.ramstate = FREE;
    step();                                  // idle, re-arbitrate
    bus.ramstate = ACCESS;
    step();                                  // re-granted, completes
    bus.dREN = 0; bus.dWEN = 0; bus.ramstate = FREE;
    step();

    // withdraw iREN mid-IGRANT
    bus.iREN = 1; bus.iaddr = 32'h44; bus.ramstate = BUSY;
    step(); step();
    bus.iREN = 0;
    step(); step();

    // continuous d and i, L=1: grants must alternate
    bus.iREN = 1; bus.dREN = 1; bus.iaddr = 32'h100; bus.daddr = 32'h900;
    seen_i = 0; seen_d = 0; prev_was_d = 0; dd_count = 0;
    for (int c = 0; c < 40; c++) begin
      bus.ramstate = (owner != 0 && bus.ramstate == BUSY) ? ACCESS : BUSY;
      #1;
      if (!bus.dwait) begin
        if (prev_was_d) dd_count++;
        prev_was_d = 1; seen_d++;
      end
      if (!bus.iwait) begin
        prev_was_d = 0; seen_i++;
      end
      #1;
      step();
    end
    chk("alt_no_dd", dd_count, 0);
    chk("alt_both_served", (seen_i > 3) && (seen_d > 3), 1'b1);
    idle_inputs();
    step(); step();

    // async reset mid-DGRANT
    bus.dREN = 1; bus.daddr = 32'h500; bus.ramstate = BUSY;
    step();
    #2 chk("pre_rst_ramREN", bus.ramREN, 1'b1);
    nRST = 0;
    #1;
    chk("arst_ramREN", bus.ramREN, 1'b0);
    chk("arst_ramWEN", bus.ramWEN, 1'b0);
    chk("arst_iwait",  bus.iwait,  1'b1);
    chk("arst_dwait",  bus.dwait,  1'b1);
    model_reset();
    @(negedge CLK);
    nRST = 1;
    idle_inputs();
    step();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (!bus.iREN || last_i_done) begin
        bus.iREN  = $urandom_range(0, 1);
        bus.iaddr = $urandom;
      end else if ($urandom_range(0, 19) == 0) begin
        bus.iREN = 0;
      end
      if (!(bus.dREN | bus.dWEN) || last_d_done) begin
        r = $urandom_range(0, 3);
        bus.dREN   = r[0];
        bus.dWEN   = r[1] & $urandom_range(0, 1);
        bus.daddr  = $urandom;
        bus.dstore = $urandom;
      end else if ($urandom_range(0, 19) == 0) begin
        bus.dREN = 0; bus.dWEN = 0;
      end
      r = $urandom_range(0, 9);
      bus.ramstate = (r < 4) ? ACCESS : (r < 7) ? BUSY : (r < 8) ? ERROR : FREE;
      bus.ramload  = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
